data_mem_responder: RTL

//  Responder end of the core's load/store data-memory interface: variable-latency byte-addressed RAM.

---
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - variable-latency byte-addressed data RAM behind a valid/ready load/store port
// Define MISALIGN_CHECK_EN to flag accesses whose address is not a multiple of the access size.
module data_mem_responder #(
   parameter int MEM_BYTES   = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);
   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic [AW-1:0] l_addr;
   logic [63:0]   l_wdata;
   logic [1:0]    l_size;
   logic          l_write, l_unsigned;
   logic [7:0]    mem [MEM_BYTES];

   logic          accept, enter_resp, misalign;
   logic [AW-1:0] a_addr;
   logic [63:0]   a_wdata;
   logic [1:0]    a_size;
   logic          a_write, a_unsigned;
   logic [AW-1:0] byte_addr [8];
   logic [7:0]    be;
   logic [63:0]   raw, load_data;
   logic          unused_addr;

   assign unused_addr = ^req_addr[63:AW];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= 4'd0;
         l_addr     <= '0;
         l_wdata    <= '0;
         l_size     <= 2'd0;
         l_write    <= 1'b0;
         l_unsigned <= 1'b0;
      end else if (accept) begin
         cnt        <= 4'(WAIT_CYCLES);
         l_addr     <= req_addr[AW-1:0];
         l_wdata    <= req_wdata;
         l_size     <= req_size;
         l_write    <= req_write;
         l_unsigned <= req_unsigned;
      end else if (state == WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // With zero wait the access commits on the accept edge, so use the live request then.
   assign a_addr     = (state == IDLE) ? req_addr[AW-1:0] : l_addr;
   assign a_wdata    = (state == IDLE) ? req_wdata        : l_wdata;
   assign a_size     = (state == IDLE) ? req_size         : l_size;
   assign a_write    = (state == IDLE) ? req_write        : l_write;
   assign a_unsigned = (state == IDLE) ? req_unsigned     : l_unsigned;

   always_comb begin
      case (a_size)
         2'd0:    be = 8'h01;
         2'd1:    be = 8'h03;
         2'd2:    be = 8'h0F;
         default: be = 8'hFF;
      endcase
      for (int i = 0; i < 8; i++) begin
         byte_addr[i]   = a_addr + AW'(i);
         raw[8*i +: 8]  = be[i] ? mem[byte_addr[i]] : 8'h00;
      end
      case (a_size)
         2'd0:    load_data = {{56{~a_unsigned & raw[7]}},  raw[7:0]};
         2'd1:    load_data = {{48{~a_unsigned & raw[15]}}, raw[15:0]};
         2'd2:    load_data = {{32{~a_unsigned & raw[31]}}, raw[31:0]};
         default: load_data = raw;
      endcase
   end

`ifdef MISALIGN_CHECK_EN
   always_comb begin
      case (a_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = a_addr[0];
         2'd2:    misalign = |a_addr[1:0];
         default: misalign = |a_addr[2:0];
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_err   <= misalign;
         rsp_rdata <= (a_write || misalign) ? 64'd0 : load_data;
         if (a_write && !misalign) begin
            for (int i = 0; i < 8; i++) begin
               if (be[i]) mem[byte_addr[i]] <= a_wdata[8*i +: 8];
            end
         end
      end
   end
endmodule
